alu_arbiter: RTL and testbench
==============================

// Module: alu_arbiter
// PURPOSE
//  Shares the single combinational KGP-miniRISC ALU between two requesters:
//  port 0 (core execute stage) and port 1 (auxiliary / debug unit).
//  Arbitrates round-robin, registers operands into the ALU, captures result
//  and flags, and returns them on per-port valid/ready response channels.
//  Sits between the requesters and the ALU instance; it contains no arithmetic.
// PARAMETERS
//  DATA_W  32  operand/result width; must match the ALU
//  SEL_W   4   ALU op-select width (ALUSel encoding, passed through unchanged)
// PORTS
//  clk             in   1       single clock, rising edge
//  rst             in   1       asynchronous, active-low reset
//  req{0,1}_valid  in   1       request present on port
//  req{0,1}_ready  out  1       port request accepted this cycle when valid&ready
//  req{0,1}_a      in   DATA_W  operand a
//  req{0,1}_b      in   DATA_W  operand b
//  req{0,1}_sel    in   SEL_W   ALU op select
//  rsp{0,1}_valid  out  1       result available for port
//  rsp{0,1}_ready  in   1       port consumes result
//  rsp{0,1}_result out  DATA_W  captured ALU result
//  rsp{0,1}_flags  out  3       {sign, zero, carry} captured with result
//  alu_a, alu_b    out  DATA_W  registered ALU operands
//  alu_sel         out  SEL_W   registered ALU select
//  alu_result      in   DATA_W  ALU result;  alu_sign/alu_zero/alu_carry in 1 each
//  busy            out  1       state != IDLE
// BEHAVIOUR
//  - Reset (rst=0, async): state IDLE, rr_ptr=0, all outputs 0 (ready, valid,
//    result, flags, alu_a/b/sel, busy). In-flight op discarded, no response.
//  - FSM IDLE -> ISSUE -> RESP -> IDLE; one op in flight, no queuing.
//  - IDLE: grant = only valid port; if both valid, port rr_ptr. reqG_ready=1 for
//    granted port only (comb.), other ready=0. On valid&ready edge: latch a,b,sel
//    into alu_a/b/sel, latch owner, rr_ptr <= ~owner, go ISSUE.
//  - ISSUE (1 cycle): ALU settles on registered operands. At edge: capture
//    alu_result and {alu_sign,alu_zero,alu_carry} into owner's rsp regs, set
//    rsp<owner>_valid=1, go RESP.
//  - Carry rule: captured carry forced 0 when sel != 4'b0000 (ALU carry is only
//    meaningful for add). sign/zero captured as-is for every op.
//  - RESP: hold rsp valid/result/flags stable until rsp<owner>_ready=1; at that
//    edge valid<=0, go IDLE. Non-owner rsp_valid stays 0. result/flags hold last
//    value after handshake.
//  - Latency: accept edge N -> rsp_valid high after edge N+1. With rsp_ready tied
//    1: handshake at N+2, next accept earliest at N+3 (1 op / 3 cycles).
//  - alu_a/b/sel change only on accept; stable through ISSUE and RESP.
//  - Requester may drop valid before ready with no effect. Unused sel codes
//    (0111,1000,1010-1111) passed through; ALU returns a.
//  - No requests while busy: both req ready=0 outside IDLE.
// CONFIGURATION
//  ALU_ARB_FIXED_PRIO_EN: defined -> fixed priority, port 0 always wins when
//  both valid; rr_ptr removed. Undefined (default) -> round-robin as above.
// TESTING
//  1. req0 a=5,b=7,sel=0000 alone, rsp0_ready=1 -> rsp0_valid after 2 edges,
//     result=12, flags=3'b000; rsp1_valid never set.
//  2. a=32'hFFFFFFFF,b=1,sel=0000 on port1 -> result=0, flags={0,1,1}.
//  3. Both ports valid continuously, sel=0011: grants alternate 0,1,0,1 after
//     reset; with ALU_ARB_FIXED_PRIO_EN all four grants go to port 0.
//  4. req0 sel=0001,b=3 with rsp0_ready=0 for 5 cycles -> rsp0_valid held,
//     result=32'hFFFFFFFD, flags={1,0,0} stable; req1 ready=0 throughout.
//  5. Assert rst=0 in ISSUE -> immediately all outputs 0, no rsp_valid after
//     release; next request serviced normally with port 0 preferred.
//  6. sel=1111, a=32'h1234 -> result=32'h1234, carry flag 0.

Source files
------------

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority (port 0 wins ties, no rr pointer).
module alu_arbiter #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned SEL_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [SEL_W-1:0]  req0_sel,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [SEL_W-1:0]  req1_sel,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [DATA_W-1:0] rsp0_result,
    output logic [2:0]        rsp0_flags,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp1_result,
    output logic [2:0]        rsp1_flags,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [SEL_W-1:0]  alu_sel,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_sign,
    input  logic              alu_zero,
    input  logic              alu_carry,
    output logic              busy
);

    typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

    state_e              r_state;
    state_e              w_state_next;
    logic                r_owner;
    logic [DATA_W-1:0]   r_alu_a;
    logic [DATA_W-1:0]   r_alu_b;
    logic [SEL_W-1:0]    r_alu_sel;
    logic                r_rsp0_valid;
    logic                r_rsp1_valid;
    logic [DATA_W-1:0]   r_rsp0_result;
    logic [DATA_W-1:0]   r_rsp1_result;
    logic [2:0]          r_rsp0_flags;
    logic [2:0]          r_rsp1_flags;

    logic                w_any_valid;
    logic                w_grant;
    logic                w_accept;
    logic                w_rsp_done;
    logic [2:0]          w_flags;
    logic [DATA_W-1:0]   w_grant_a;
    logic [DATA_W-1:0]   w_grant_b;
    logic [SEL_W-1:0]    w_grant_sel;

`ifndef ALU_ARB_FIXED_PRIO_EN
    logic                r_rr_ptr;
`endif

    always_comb begin
        w_any_valid = req0_valid | req1_valid;
`ifdef ALU_ARB_FIXED_PRIO_EN
        w_grant     = ~req0_valid;
`else
        w_grant     = (req0_valid & req1_valid) ? r_rr_ptr : req1_valid;
`endif
        w_accept    = (r_state == StIdle) & w_any_valid;
        w_rsp_done  = r_owner ? rsp1_ready : rsp0_ready;
        w_grant_a   = w_grant ? req1_a   : req0_a;
        w_grant_b   = w_grant ? req1_b   : req0_b;
        w_grant_sel = w_grant ? req1_sel : req0_sel;
        // ALU carry is only meaningful for add (sel 0)
        w_flags     = {alu_sign, alu_zero, alu_carry & (r_alu_sel == '0)};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (w_accept) w_state_next = StIssue;
            StIssue: w_state_next = StResp;
            StResp:  if (w_rsp_done) w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_comb begin
        req0_ready = rst & (r_state == StIdle) & req0_valid & ~w_grant;
        req1_ready = rst & (r_state == StIdle) & req1_valid & w_grant;
        busy       = (r_state != StIdle);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_owner       <= 1'b0;
            r_alu_a       <= '0;
            r_alu_b       <= '0;
            r_alu_sel     <= '0;
            r_rsp0_valid  <= 1'b0;
            r_rsp1_valid  <= 1'b0;
            r_rsp0_result <= '0;
            r_rsp1_result <= '0;
            r_rsp0_flags  <= '0;
            r_rsp1_flags  <= '0;
`ifndef ALU_ARB_FIXED_PRIO_EN
            r_rr_ptr      <= 1'b0;
`endif
        end else begin
            if (w_accept) begin
                r_owner   <= w_grant;
                r_alu_a   <= w_grant_a;
                r_alu_b   <= w_grant_b;
                r_alu_sel <= w_grant_sel;
`ifndef ALU_ARB_FIXED_PRIO_EN
                r_rr_ptr  <= ~w_grant;
`endif
            end
            if (r_state == StIssue) begin
                if (r_owner) begin
                    r_rsp1_valid  <= 1'b1;
                    r_rsp1_result <= alu_result;
                    r_rsp1_flags  <= w_flags;
                end else begin
                    r_rsp0_valid  <= 1'b1;
                    r_rsp0_result <= alu_result;
                    r_rsp0_flags  <= w_flags;
                end
            end
            if ((r_state == StResp) && w_rsp_done) begin
                r_rsp0_valid <= 1'b0;
                r_rsp1_valid <= 1'b0;
            end
        end
    end

    assign alu_a       = r_alu_a;
    assign alu_b       = r_alu_b;
    assign alu_sel     = r_alu_sel;
    assign rsp0_valid  = r_rsp0_valid;
    assign rsp1_valid  = r_rsp1_valid;
    assign rsp0_result = r_rsp0_result;
    assign rsp1_result = r_rsp1_result;
    assign rsp0_flags  = r_rsp0_flags;
    assign rsp1_flags  = r_rsp1_flags;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: stub ALU, directed scenarios, then randomized transactions
// checked against a transaction-level model of arbitration and response capture.
module tb_alu_arbiter;

    logic        clk;
    logic        rst;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]  req0_sel, req1_sel;
    logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [31:0] rsp0_result, rsp1_result;
    logic [2:0]  rsp0_flags, rsp1_flags;
    logic [31:0] alu_a, alu_b, alu_result;
    logic [3:0]  alu_sel;
    logic        alu_sign, alu_zero, alu_carry, busy;

    int          n_checks;
    int          n_errors;
    logic        exp_pref;
    logic [31:0] m_res [2];
    logic [2:0]  m_flg [2];

    alu_arbiter #(.DATA_W(32), .SEL_W(4)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_sel(req0_sel),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_sel(req1_sel),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp0_result(rsp0_result), .rsp0_flags(rsp0_flags),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp1_result(rsp1_result), .rsp1_flags(rsp1_flags),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_result(alu_result), .alu_sign(alu_sign), .alu_zero(alu_zero),
        .alu_carry(alu_carry), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Returns {carry/borrow, result}; unused codes return a
    function automatic logic [32:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                           input logic [3:0] sel);
        logic [32:0] t;
        case (sel)
            4'd0:    t = {1'b0, a} + {1'b0, b};
            4'd1:    t = {1'b0, a} - {1'b0, b};
            4'd2:    t = {1'b0, a & b};
            4'd3:    t = {1'b0, a | b};
            4'd4:    t = {1'b0, a ^ b};
            4'd5:    t = {1'b0, a << b[4:0]};
            4'd6:    t = {1'b0, a >> b[4:0]};
            4'd9:    t = {1'b0, 32'($signed(a) >>> b[4:0])};
            default: t = {1'b0, a};
        endcase
        return t;
    endfunction

    always_comb begin
        {alu_carry, alu_result} = alu_fn(alu_a, alu_b, alu_sel);
        alu_sign = alu_result[31];
        alu_zero = (alu_result == 32'd0);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_rdy"}, {req0_ready, req1_ready}, 0);
        chk({tag, "_rspv"}, {rsp0_valid, rsp1_valid}, 0);
        chk({tag, "_res"}, {rsp0_result, rsp1_result}, 0);
        chk({tag, "_flg"}, {rsp0_flags, rsp1_flags}, 0);
        chk({tag, "_alu"}, {alu_a, alu_b}, 0);
        chk({tag, "_sel"}, alu_sel, 0);
    endtask

    task automatic model_reset();
        exp_pref = 1'b0;
        m_res[0] = '0; m_res[1] = '0;
        m_flg[0] = '0; m_flg[1] = '0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        req0_valid = 0; req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0;
        req0_a = 0; req0_b = 0; req0_sel = 0; req1_a = 0; req1_b = 0; req1_sel = 0;
        tick();
        check_zero("reset");
        rst = 1'b1;
        model_reset();
    endtask

    // One full transaction: request, accept, issue, response held for `hold` cycles.
    task automatic run_op(input logic [1:0] v,
                          input logic [31:0] a0, input logic [31:0] b0, input logic [3:0] s0,
                          input logic [31:0] a1, input logic [31:0] b1, input logic [3:0] s1,
                          input int hold, output logic owin);
        logic        win;
        logic [31:0] ea, eb;
        logic [3:0]  es;
        logic [32:0] t;
        rsp0_ready = 0; rsp1_ready = 0;
        req0_valid = v[0]; req0_a = a0; req0_b = b0; req0_sel = s0;
        req1_valid = v[1]; req1_a = a1; req1_b = b1; req1_sel = s1;
        #1;
        win  = (v == 2'b11) ? exp_pref : v[1];
        owin = req1_ready;
        chk("grant_r0", req0_ready, v[0] & ~win);
        chk("grant_r1", req1_ready, v[1] & win);
        chk("idle_busy", busy, 0);
        ea = win ? a1 : a0;
        eb = win ? b1 : b0;
        es = win ? s1 : s0;
        tick();
`ifdef ALU_ARB_FIXED_PRIO_EN
        exp_pref = 1'b0;
`else
        exp_pref = ~win;
`endif
        // Both ports now push different operands; nothing may be accepted
        req0_valid = 1; req1_valid = 1;
        req0_a = ~a0; req1_a = ~a1; req0_sel = ~s0; req1_sel = ~s1;
        #1;
        chk("issue_busy", busy, 1);
        chk("issue_rdy", {req0_ready, req1_ready}, 0);
        chk("issue_alu", {alu_a, alu_b}, {ea, eb});
        chk("issue_sel", alu_sel, es);
        chk("issue_rspv", {rsp0_valid, rsp1_valid}, 0);
        t = alu_fn(ea, eb, es);
        m_res[win] = t[31:0];
        m_flg[win] = {t[31], t[31:0] == 32'd0, (es == 4'd0) ? t[32] : 1'b0};
        tick();
        for (int i = 0; i <= hold; i++) begin
            if (win) rsp0_ready = 1'($urandom_range(0, 1));
            else     rsp1_ready = 1'($urandom_range(0, 1));
            if (i == hold) begin
                if (win) rsp1_ready = 1; else rsp0_ready = 1;
            end
            #1;
            chk("resp_valid", {rsp1_valid, rsp0_valid}, win ? 2'b10 : 2'b01);
            chk("resp_res", {rsp0_result, rsp1_result}, {m_res[0], m_res[1]});
            chk("resp_flg", {rsp0_flags, rsp1_flags}, {m_flg[0], m_flg[1]});
            chk("resp_rdy", {req0_ready, req1_ready}, 0);
            chk("resp_alu", {alu_a, alu_sel}, {ea, es});
            tick();
        end
        chk("done_valid", {rsp0_valid, rsp1_valid}, 0);
        chk("done_busy", busy, 0);
        chk("done_res", {rsp0_result, rsp1_result}, {m_res[0], m_res[1]});
        req0_valid = 0; req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0;
    endtask

    initial begin
        logic       w;
        logic [3:0] exp_seq;
        n_checks = 0;
        n_errors = 0;
        model_reset();
        do_reset();

        // Add 5+7 on port 0 alone
        run_op(2'b01, 32'd5, 32'd7, 4'd0, 32'd0, 32'd0, 4'd0, 0, w);
        chk("t1_owner", w, 0);
        chk("t1_res", rsp0_result, 32'd12);
        chk("t1_flg", rsp0_flags, 3'b000);
        chk("t1_rsp1", rsp1_result, 32'd0);

        // Add overflow on port 1
        run_op(2'b10, 32'd0, 32'd0, 4'd0, 32'hFFFF_FFFF, 32'd1, 4'd0, 0, w);
        chk("t2_owner", w, 1);
        chk("t2_res", rsp1_result, 32'd0);
        chk("t2_flg", rsp1_flags, 3'b011);

        // Both ports valid continuously after reset
        do_reset();
`ifdef ALU_ARB_FIXED_PRIO_EN
        exp_seq = 4'b0000;
`else
        exp_seq = 4'b1010;
`endif
        for (int i = 0; i < 4; i++) begin
            run_op(2'b11, 32'(i), 32'd3, 4'd3, 32'(i + 16), 32'd5, 4'd3, 0, w);
            chk("t3_grant", w, exp_seq[i]);
        end

        // Subtract with response held off for 5 cycles
        run_op(2'b01, 32'd0, 32'd3, 4'd1, 32'd0, 32'd0, 4'd0, 5, w);
        chk("t4_res", rsp0_result, 32'hFFFF_FFFD);
        chk("t4_flg", rsp0_flags, 3'b100);

        // Reset asserted during ISSUE
        req0_valid = 1; req0_a = 32'd9; req0_b = 32'd1; req0_sel = 4'd0;
        req1_valid = 0;
        #1;
        tick();
        req0_valid = 0;
        rst = 1'b0;
        #1;
        check_zero("t5_rst");
        tick();
        rst = 1'b1;
        model_reset();
        tick();
        tick();
        chk("t5_norsp", {rsp0_valid, rsp1_valid, busy}, 0);
        run_op(2'b11, 32'd1, 32'd2, 4'd0, 32'd3, 32'd4, 4'd0, 0, w);
        chk("t5_pref0", w, 0);

        // Unused select code passes a through, carry forced 0
        run_op(2'b01, 32'h1234, 32'd9, 4'hF, 32'd0, 32'd0, 4'd0, 0, w);
        chk("t6_res", rsp0_result, 32'h1234);
        chk("t6_carry", rsp0_flags[0], 0);

        // Randomized transactions
        for (int n = 0; n < 60; n++) begin
            run_op(2'($urandom_range(1, 3)),
                   $urandom, $urandom, 4'($urandom_range(0, 15)),
                   $urandom, $urandom, 4'($urandom_range(0, 15)),
                   int'($urandom_range(0, 3)), w);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
